// File: rtl/dmem_port_arbiter.sv
// Purpose : shares one synchronous data-memory port between requesters A and B
//           (round-robin arbitration with a bounded burst).
// Latency : grant is combinational in the request cycle. The response (x_rvalid/x_rdata)
//           comes exactly 1 cycle after the grant.
// Backpressure: a requester holds x_req until x_gnt. A loser simply waits and its stall
//           counter counts the wait. Grants may be back-to-back with no bubbles.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   a_req/a_addr/a_wdata/a_wmask -> a_gnt, a_rvalid, a_rdata    requester A (wmask 0 = read)
//   b_*                   identical set for requester B
//   mem_cen/mem_addr/mem_wdata/mem_wmask -> memory port, mem_data <- read data (1-cycle latency)
//   a_stall_cnt/b_stall_cnt   saturating count of cycles spent requesting without a grant
module dmem_port_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic [31:0]      a_addr,
   input  logic [31:0]      a_wdata,
   input  logic [3:0]       a_wmask,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [31:0]      a_rdata,
   input  logic             b_req,
   input  logic [31:0]      b_addr,
   input  logic [31:0]      b_wdata,
   input  logic [3:0]       b_wmask,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [31:0]      b_rdata,
   output logic             mem_cen,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wmask,
   input  logic [31:0]      mem_data,
   output logic [CNT_W-1:0] a_stall_cnt,
   output logic [CNT_W-1:0] b_stall_cnt
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

   // owner_q: 0 = A, 1 = B. burst_q counts consecutive grants to the owner.
   logic          owner_q;
   logic [BW-1:0] burst_q;
   logic          owner_keeps;
   logic          gnt_a;
   logic          gnt_b;

   logic [31:0]      last_addr_q;
   logic [31:0]      last_wdata_q;
   logic             a_rvalid_q;
   logic             b_rvalid_q;
   logic [31:0]      a_hold_q;
   logic [31:0]      b_hold_q;
   logic [CNT_W-1:0] a_stall_q;
   logic [CNT_W-1:0] b_stall_q;

   // Under contention the owner keeps the port only while it has a burst in progress
   // that is still below the limit. burst_q==0 (only after reset) means nobody owns a burst,
   // so the non-owner (A, since reset makes B the owner) wins the first conflict.
   always_comb begin
      owner_keeps = (burst_q != '0) && (burst_q < BURST_LIM);
      gnt_a       = 1'b0;
      gnt_b       = 1'b0;
      if (!reset) begin
         if (a_req && b_req) begin
            if (owner_keeps) begin
               gnt_a = ~owner_q;
               gnt_b = owner_q;
            end else begin
               gnt_a = owner_q;
               gnt_b = ~owner_q;
            end
         end else begin
            gnt_a = a_req;
            gnt_b = b_req;
         end
      end
   end

   assign a_gnt = gnt_a;
   assign b_gnt = gnt_b;

   // Memory port: granted requester's fields. When idle, the address/data hold their last
   // granted values so the RAM inputs do not toggle needlessly.
   always_comb begin
      mem_cen   = gnt_a | gnt_b;
      mem_addr  = last_addr_q;
      mem_wdata = last_wdata_q;
      mem_wmask = 4'b0000;
      if (gnt_a) begin
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
         mem_wmask = a_wmask;
      end else if (gnt_b) begin
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
         mem_wmask = b_wmask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_addr_q  <= '0;
         last_wdata_q <= '0;
      end else if (mem_cen) begin
         last_addr_q  <= mem_addr;
         last_wdata_q <= mem_wdata;
      end
   end

   // Ownership tracking. gnt_b doubles as the id of the granted requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= 1'b1;
         burst_q <= '0;
      end else if (gnt_a || gnt_b) begin
         if (gnt_b == owner_q) begin
            if (burst_q < BURST_LIM) begin
               burst_q <= burst_q + BW'(1);
            end
         end else begin
            owner_q <= gnt_b;
            burst_q <= BW'(1);
         end
      end
   end

   // Responses: rvalid is the grant delayed by the memory latency. It also acknowledges writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_hold_q   <= '0;
         b_hold_q   <= '0;
      end else begin
         a_rvalid_q <= gnt_a;
         b_rvalid_q <= gnt_b;
         if (a_rvalid_q) begin
            a_hold_q <= mem_data;
         end
         if (b_rvalid_q) begin
            b_hold_q <= mem_data;
         end
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   // Live memory data in the response cycle, captured copy afterwards.
   assign a_rdata  = a_rvalid_q ? mem_data : a_hold_q;
   assign b_rdata  = b_rvalid_q ? mem_data : b_hold_q;

   // Stall counters saturate at all-ones and never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_stall_q <= '0;
         b_stall_q <= '0;
      end else begin
         if (a_req && !gnt_a && (a_stall_q != '1)) begin
            a_stall_q <= a_stall_q + CNT_W'(1);
         end
         if (b_req && !gnt_b && (b_stall_q != '1)) begin
            b_stall_q <= b_stall_q + CNT_W'(1);
         end
      end
   end

   assign a_stall_cnt = a_stall_q;
   assign b_stall_cnt = b_stall_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : bench for dmem_port_arbiter. dut0 uses MAX_BURST=4/CNT_W=16 and dut1 uses
//           MAX_BURST=1/CNT_W=4. Each has its own RAM model.
// Latency : the reference model advances on posedge. Outputs are sampled on negedge.
// Backpressure: requests are driven as levels. The model decides who should win.
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_req     [2];
   logic [31:0] a_addr    [2];
   logic [31:0] a_wdata   [2];
   logic [3:0]  a_wmask   [2];
   logic        a_gnt     [2];
   logic        a_rvalid  [2];
   logic [31:0] a_rdata   [2];
   logic        b_req     [2];
   logic [31:0] b_addr    [2];
   logic [31:0] b_wdata   [2];
   logic [3:0]  b_wmask   [2];
   logic        b_gnt     [2];
   logic        b_rvalid  [2];
   logic [31:0] b_rdata   [2];
   logic        mem_cen   [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_wmask [2];
   logic [31:0] mem_data  [2];
   logic [15:0] a_stall0, b_stall0;
   logic [3:0]  a_stall1, b_stall1;

   int checks = 0;
   int errors = 0;

   dmem_port_arbiter #(.MAX_BURST(4), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset),
      .a_req(a_req[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]), .a_wmask(a_wmask[0]),
      .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
      .b_req(b_req[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]), .b_wmask(b_wmask[0]),
      .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
      .mem_cen(mem_cen[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_wmask(mem_wmask[0]), .mem_data(mem_data[0]),
      .a_stall_cnt(a_stall0), .b_stall_cnt(b_stall0));

   dmem_port_arbiter #(.MAX_BURST(1), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset),
      .a_req(a_req[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]), .a_wmask(a_wmask[1]),
      .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
      .b_req(b_req[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]), .b_wmask(b_wmask[1]),
      .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
      .mem_cen(mem_cen[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_wmask(mem_wmask[1]), .mem_data(mem_data[1]),
      .a_stall_cnt(a_stall1), .b_stall_cnt(b_stall1));

   // ---------------- memory environment + reference model ----------------
   logic [31:0] ram [2][256];
   bit          ram_init = 1'b0;

   int          mb   [2] = '{4, 1};
   int          smax [2] = '{65535, 15};
   logic        m_last [2];          // last requester served (1 = B)
   int          m_run  [2];          // consecutive services to m_last, capped at the burst limit
   int          m_sa [2], m_sb [2];
   logic        m_rva [2], m_rvb [2];
   logic [31:0] m_rda [2], m_rdb [2], m_addr [2], m_wd [2];

   function automatic logic [31:0] init_word(int i);
      return 32'(32'h9E3779B9 * (i + 1));
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Expected {b_gnt, a_gnt}. Under contention the last winner may continue only while it
   // has a started run shorter than the burst limit. Otherwise the other side gets its turn.
   function automatic logic [1:0] exp_gnt(int d);
      bit keep;
      bit win_b;
      if (reset) return 2'b00;
      if (a_req[d] && b_req[d]) begin
         keep  = (m_run[d] > 0) && (m_run[d] < mb[d]);
         win_b = keep ? m_last[d] : !m_last[d];
         return win_b ? 2'b10 : 2'b01;
      end
      return {b_req[d], a_req[d]};
   endfunction

   always @(posedge clk) begin
      logic [1:0]  g;
      logic [31:0] w;
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) begin
            ram[0][i] = init_word(i);
            ram[1][i] = init_word(i);
         end
         ram_init = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
         g = exp_gnt(d);
         if (reset) begin
            m_last[d] = 1'b1; m_run[d] = 0; m_sa[d] = 0; m_sb[d] = 0;
            m_rva[d] = 1'b0; m_rvb[d] = 1'b0; m_rda[d] = '0; m_rdb[d] = '0;
            m_addr[d] = '0; m_wd[d] = '0;
         end else begin
            m_rva[d] = g[0];
            m_rvb[d] = g[1];
            if (g[0]) begin
               w = ram[d][a_addr[d][9:2]];
               m_rda[d] = w; m_addr[d] = a_addr[d]; m_wd[d] = a_wdata[d];
            end
            if (g[1]) begin
               w = ram[d][b_addr[d][9:2]];
               m_rdb[d] = w; m_addr[d] = b_addr[d]; m_wd[d] = b_wdata[d];
            end
            if (a_req[d] && !g[0] && m_sa[d] < smax[d]) m_sa[d]++;
            if (b_req[d] && !g[1] && m_sb[d] < smax[d]) m_sb[d]++;
            if (g != 2'b00) begin
               if (g[1] == m_last[d]) m_run[d] = (m_run[d] + 1 > mb[d]) ? mb[d] : m_run[d] + 1;
               else begin
                  m_last[d] = g[1];
                  m_run[d]  = 1;
               end
            end
         end
         // RAM: read-before-write, 1-cycle read latency
         if (mem_cen[d]) begin
            mem_data[d] <= ram[d][mem_addr[d][9:2]];
            ram[d][mem_addr[d][9:2]] = merge(ram[d][mem_addr[d][9:2]], mem_wdata[d], mem_wmask[d]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      for (int d = 0; d < 2; d++) begin
         a_req[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0; a_wmask[d] = '0;
         b_req[d] = 1'b0; b_addr[d] = '0; b_wdata[d] = '0; b_wmask[d] = '0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      a_req[0] = 1'b1; b_req[0] = 1'b1; a_req[1] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if ({b_gnt[0], a_gnt[0]} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {b_gnt[0], a_gnt[0]}); end
      checks++; if (a_gnt[1] !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", a_gnt[1]); end
      checks++; if (mem_cen[0] !== 1'b0 || mem_wmask[0] !== 4'h0) begin errors++; $display("FAIL reset_mem: got cen=%b wmask=%h want 0/0", mem_cen[0], mem_wmask[0]); end
      checks++; if ({b_rvalid[0], a_rvalid[0]} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {b_rvalid[0], a_rvalid[0]}); end
      checks++; if (a_rdata[0] !== 32'h0 || b_rdata[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_rdata[0], b_rdata[0]); end
      checks++; if (a_stall0 !== 16'h0 || b_stall0 !== 16'h0) begin errors++; $display("FAIL reset_stall: got %0d/%0d want 0/0", a_stall0, b_stall0); end
      @(posedge clk);
      #1 reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single_read();
      do_reset();
      a_req[0] = 1'b1; a_addr[0] = 32'h10;
      @(negedge clk);
      checks++; if ({b_gnt[0], a_gnt[0]} !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", {b_gnt[0], a_gnt[0]}); end
      checks++; if (mem_cen[0] !== 1'b1 || mem_addr[0] !== 32'h10) begin errors++; $display("FAIL single_mem: got cen=%b addr=%h want 1/10", mem_cen[0], mem_addr[0]); end
      @(posedge clk); #1 a_req[0] = 1'b0;
      @(negedge clk);
      checks++; if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== init_word(4)) begin errors++; $display("FAIL single_resp: got v=%b d=%h want 1/%h", a_rvalid[0], a_rdata[0], init_word(4)); end
      checks++; if (b_rvalid[0] !== 1'b0) begin errors++; $display("FAIL single_b_rvalid: got %b want 0", b_rvalid[0]); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== init_word(4)) begin errors++; $display("FAIL single_hold: got v=%b d=%h want 0/%h", a_rvalid[0], a_rdata[0], init_word(4)); end
      @(posedge clk); #1;
   endtask

   task automatic test_burst_pattern();
      logic exp_b [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      a_req[0] = 1'b1; a_addr[0] = 32'h40;
      b_req[0] = 1'b1; b_addr[0] = 32'h80;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         checks++; if ({b_gnt[0], a_gnt[0]} !== {exp_b[k], !exp_b[k]}) begin errors++; $display("FAIL burst_gnt[%0d]: got %b want %b", k, {b_gnt[0], a_gnt[0]}, {exp_b[k], !exp_b[k]}); end
         if (k == 4) begin
            checks++; if (b_stall0 !== 16'd4) begin errors++; $display("FAIL burst_b_stall: got %0d want 4", b_stall0); end
         end
         if (k == 8) begin
            checks++; if (a_stall0 !== 16'd4) begin errors++; $display("FAIL burst_a_stall: got %0d want 4", a_stall0); end
         end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_write_then_read();
      logic [31:0] pre;
      logic [31:0] post;
      pre  = init_word(8);
      post = {pre[31:16], 16'hBEEF};
      do_reset();
      a_req[0] = 1'b1; a_addr[0] = 32'h20; a_wdata[0] = 32'hDEADBEEF; a_wmask[0] = 4'b0011;
      @(negedge clk);
      checks++; if (a_gnt[0] !== 1'b1 || mem_wmask[0] !== 4'b0011 || mem_wdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_issue: got gnt=%b wmask=%h wdata=%h want 1/3/deadbeef", a_gnt[0], mem_wmask[0], mem_wdata[0]); end
      @(posedge clk); #1;
      a_req[0] = 1'b0; a_wmask[0] = 4'b0000;
      b_req[0] = 1'b1; b_addr[0] = 32'h20;
      @(negedge clk);
      checks++; if (b_gnt[0] !== 1'b1) begin errors++; $display("FAIL wr_b_gnt: got %b want 1", b_gnt[0]); end
      checks++; if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== pre) begin errors++; $display("FAIL wr_ack: got v=%b d=%h want 1/%h", a_rvalid[0], a_rdata[0], pre); end
      @(posedge clk); #1 b_req[0] = 1'b0;
      @(negedge clk);
      checks++; if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== post) begin errors++; $display("FAIL wr_readback: got v=%b d=%h want 1/%h", b_rvalid[0], b_rdata[0], post); end
      checks++; if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== pre) begin errors++; $display("FAIL wr_ack_pulse: got v=%b d=%h want 0/%h", a_rvalid[0], a_rdata[0], pre); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_req[0] = 1'b1; a_addr[0] = 32'h30;
      b_req[0] = 1'b1; b_addr[0] = 32'h34;
      @(negedge clk);
      checks++; if (a_gnt[0] !== 1'b1) begin errors++; $display("FAIL rstmid_first: got %b want 1", a_gnt[0]); end
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      checks++; if ({b_gnt[0], a_gnt[0], mem_cen[0]} !== 3'b000) begin errors++; $display("FAIL rstmid_gnt: got %b want 000", {b_gnt[0], a_gnt[0], mem_cen[0]}); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== 32'h0) begin errors++; $display("FAIL rstmid_resp: got v=%b d=%h want 0/0", a_rvalid[0], a_rdata[0]); end
      checks++; if (a_stall0 !== 16'h0 || b_stall0 !== 16'h0) begin errors++; $display("FAIL rstmid_stall: got %0d/%0d want 0/0", a_stall0, b_stall0); end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if ({b_gnt[0], a_gnt[0]} !== 2'b01) begin errors++; $display("FAIL rstmid_owner: got %b want 01", {b_gnt[0], a_gnt[0]}); end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic test_alternate();
      logic exp_b [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic ev_a;
      logic ev_b;
      do_reset();
      a_req[1] = 1'b1; a_addr[1] = 32'h44;
      b_req[1] = 1'b1; b_addr[1] = 32'h48;
      for (int k = 0; k < 6; k++) begin
         ev_a = (k > 0) && !exp_b[(k > 0) ? k - 1 : 0];
         ev_b = (k > 0) &&  exp_b[(k > 0) ? k - 1 : 0];
         @(negedge clk);
         checks++; if ({b_gnt[1], a_gnt[1]} !== {exp_b[k], !exp_b[k]}) begin errors++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, {b_gnt[1], a_gnt[1]}, {exp_b[k], !exp_b[k]}); end
         checks++; if ({b_rvalid[1], a_rvalid[1]} !== {ev_b, ev_a}) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b want %b", k, {b_rvalid[1], a_rvalid[1]}, {ev_b, ev_a}); end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      a_req[1] = 1'b1; b_req[1] = 1'b1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         checks++; if ({b_gnt[1], a_gnt[1]} !== exp_gnt(1)) begin errors++; $display("FAIL sat_gnt[%0d]: got %b want %b", k, {b_gnt[1], a_gnt[1]}, exp_gnt(1)); end
         checks++; if (b_stall1 !== 4'(m_sb[1])) begin errors++; $display("FAIL sat_b_model[%0d]: got %0d want %0d", k, b_stall1, m_sb[1]); end
         if (k == 40) begin
            checks++; if (a_stall1 !== 4'hF || b_stall1 !== 4'hF) begin errors++; $display("FAIL sat_final: got %0d/%0d want 15/15", a_stall1, b_stall1); end
         end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_random();
      logic [1:0]  g;
      logic [3:0]  e_m;
      logic [31:0] e_a;
      logic [31:0] e_w;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         a_req[0]   = ($urandom_range(0, 3) != 0);
         b_req[0]   = ($urandom_range(0, 3) != 0);
         a_addr[0]  = $urandom();
         b_addr[0]  = $urandom();
         a_wdata[0] = $urandom();
         b_wdata[0] = $urandom();
         a_wmask[0] = $urandom_range(0, 1) ? 4'($urandom()) : 4'h0;
         b_wmask[0] = $urandom_range(0, 1) ? 4'($urandom()) : 4'h0;
         @(negedge clk);
         g   = exp_gnt(0);
         e_m = g[0] ? a_wmask[0] : (g[1] ? b_wmask[0] : 4'h0);
         e_a = g[0] ? a_addr[0]  : (g[1] ? b_addr[0]  : m_addr[0]);
         e_w = g[0] ? a_wdata[0] : (g[1] ? b_wdata[0] : m_wd[0]);
         checks++; if ({b_gnt[0], a_gnt[0]} !== g) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", k, {b_gnt[0], a_gnt[0]}, g); end
         checks++; if (mem_cen[0] !== (|g) || mem_wmask[0] !== e_m) begin errors++; $display("FAIL rnd_cen[%0d]: got %b/%h want %b/%h", k, mem_cen[0], mem_wmask[0], |g, e_m); end
         checks++; if (mem_addr[0] !== e_a || mem_wdata[0] !== e_w) begin errors++; $display("FAIL rnd_mem[%0d]: got %h/%h want %h/%h", k, mem_addr[0], mem_wdata[0], e_a, e_w); end
         checks++; if ({b_rvalid[0], a_rvalid[0]} !== {m_rvb[0], m_rva[0]}) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", k, {b_rvalid[0], a_rvalid[0]}, {m_rvb[0], m_rva[0]}); end
         checks++; if (a_rdata[0] !== m_rda[0]) begin errors++; $display("FAIL rnd_a_rdata[%0d]: got %h want %h", k, a_rdata[0], m_rda[0]); end
         checks++; if (b_rdata[0] !== m_rdb[0]) begin errors++; $display("FAIL rnd_b_rdata[%0d]: got %h want %h", k, b_rdata[0], m_rdb[0]); end
         checks++; if (a_stall0 !== 16'(m_sa[0]) || b_stall0 !== 16'(m_sb[0])) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d/%0d", k, a_stall0, b_stall0, m_sa[0], m_sb[0]); end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_burst_pattern();
      test_write_then_read();
      test_reset_mid();
      test_alternate();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
